// File: rtl/ivs_dma_pkg.sv
// Shared types, constants and helpers for the IVS DMA request arbiters.
package ivs_dma_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;

  // Upper bounds for the packed weight vector handled by weight_field().
  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_W_W   = 8;
  localparam int unsigned WGT_VEC_W = MAX_REQ * MAX_W_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Extract field idx (w_w bits wide) from a packed per-channel weight vector.
  function automatic logic [MAX_W_W-1:0] weight_field(
    input logic [WGT_VEC_W-1:0] vec,
    input int unsigned          idx,
    input int unsigned          w_w
  );
    logic [WGT_VEC_W-1:0] w_sh;
    logic [MAX_W_W-1:0]   w_mask;
    w_sh   = vec >> (idx * w_w);
    w_mask = MAX_W_W'((32'd1 << w_w) - 32'd1);
    return MAX_W_W'(w_sh) & w_mask;
  endfunction

endpackage

// File: rtl/ivs_dma_rr_arb_if.sv
// Channel-request / bus-handshake bundle between DMA channels and the arbiter.
interface ivs_dma_rr_arb_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_W   = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]     req;
  logic                 resp;
  logic                 mode;
  logic [N_REQ*W_W-1:0] weight;
  logic [N_REQ-1:0]     ack;
  logic                 comreq;
  logic [IDX_W-1:0]     grant_o;

  // Arbiter side: drives the bus request, grant index and per-channel ack.
  modport master (
    input  req, resp, mode, weight,
    output ack, comreq, grant_o
  );

  // Channel/bus side.
  modport slave (
    output req, resp, mode, weight,
    input  ack, comreq, grant_o
  );
endinterface

// File: rtl/ivs_rr_pick.sv
// Combinational winner pick: rotating round-robin after i_last, or lowest index.
module ivs_rr_pick
  import ivs_dma_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  input  logic             i_mode,
  output logic [IDX_W-1:0] o_win,
  output logic             o_any
);

  logic        w_found;
  int unsigned w_idx;

  // Scan order ends at i_last itself so a lone requester can win repeatedly.
  always_comb begin
    o_win   = '0;
    o_any   = |i_req;
    w_found = 1'b0;
    w_idx   = 0;
    if (i_mode == MODE_FIX) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!w_found && i_req[IDX_W'(i)]) begin
          o_win   = IDX_W'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        w_idx = (32'(i_last) + k) % N_REQ;
        if (!w_found && i_req[IDX_W'(w_idx)]) begin
          o_win   = IDX_W'(w_idx);
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ivs_dma_rr_arb.sv
// N-channel DMA request arbiter: round-robin / fixed priority with weighted bursts.
module ivs_dma_rr_arb
  import ivs_dma_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_W   = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ivs_dma_rr_arb_if.master  bus
);

  arb_state_e       r_state, w_nxt_state;
  logic [IDX_W-1:0] r_grant, w_nxt_grant;
  logic [W_W-1:0]   r_credit, w_nxt_credit;
  logic [IDX_W-1:0] w_win;
  logic             w_any;
  logic [W_W-1:0]   w_wsel;
  logic             w_burst;
  logic [N_REQ-1:0] w_ack;

  ivs_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (bus.req),
    .i_last (r_grant),
    .i_mode (bus.mode),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  assign w_wsel  = W_W'(weight_field(WGT_VEC_W'(bus.weight), 32'(w_win), W_W));
  assign w_burst = (r_credit != '0) && bus.req[r_grant];

  // State, grant index and burst credit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_credit <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_grant  <= w_nxt_grant;
      r_credit <= w_nxt_credit;
    end
  end

  // Arbitrate in IDLE; hold the grant in BUSY until the bus response.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_grant  = r_grant;
    w_nxt_credit = r_credit;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_nxt_state = ST_BUSY;
          if (w_burst) begin
            w_nxt_credit = r_credit - W_W'(1);
          end else begin
            w_nxt_grant  = w_win;
            w_nxt_credit = (w_wsel == '0) ? '0 : w_wsel - W_W'(1);
          end
        end
      end
      ST_BUSY: begin
        if (bus.resp) begin
          w_nxt_state = ST_IDLE;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // One-hot ack to the held winner, coincident with the response strobe.
  always_comb begin
    w_ack = '0;
    if ((r_state == ST_BUSY) && bus.resp) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        w_ack[i] = (r_grant == IDX_W'(i));
      end
    end
  end

  assign bus.ack     = w_ack;
  assign bus.comreq  = (r_state == ST_BUSY);
  assign bus.grant_o = r_grant;

endmodule

// File: doc/ivs_dma_rr_arb.md
Name: ivs_dma_rr_arb

Overview:
Parametrised N-channel DMA request arbiter, successor to the fixed 2/3/4-input round-robin arbiters. It sits between the DMA channel request lines and the shared bus master port. It latches one winner per transaction, asserts a common request, and routes the single bus response back as a per-channel ack. Adds run-time selectable round-robin / fixed-priority mode and per-channel weighted bursts (consecutive grants).

Parameters:
N_REQ, 4, number of requesting channels (1..16)
IDX_W, $clog2(N_REQ) (min 1), grant index width
W_W, 4, width of each per-channel weight field

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-channel request, level, held until acked
resp  in  1  bus response/done strobe, one-cycle pulse per transaction
mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
weight  in  N_REQ*W_W  per-channel consecutive-grant budget; field i = bits [i*W_W +: W_W]; 0 treated as 1
ack  out  N_REQ  one-hot ack to the granted channel
comreq  out  1  common request to bus, high while a transaction is outstanding
grant_o  out  IDX_W  index of the current/last winner

Behaviour:
- Reset values: comreq=0, grant_o=0, credit=0, state IDLE, ack=0.
- FSM states:
  - IDLE: if |req, latch winner into grant_o, go BUSY; comreq=1 from the next cycle (1-cycle arbitration latency).
  - BUSY: comreq=1; on resp, return to IDLE; comreq=0 the following cycle.
- Back-to-back: earliest next comreq is 2 cycles after resp.
- ack = resp & (state==BUSY), decoded one-hot on grant_o, combinational in the same cycle as resp.
- resp while IDLE: ignored, ack=0, no state change.
- Winner selection, evaluated only in IDLE with |req:
  - Burst rule (both modes): if credit!=0 and req[grant_o]==1, the same channel wins again.
  - Otherwise, mode 0: first set req bit scanning grant_o+1, grant_o+2, ... modulo N_REQ, ending at grant_o itself. From reset (grant_o=0), req=all-ones grants 1 first; this matches the legacy arbiters.
  - Otherwise, mode 1: lowest set req index.
- Credit counter (W_W bits):
  - On a new winner, load max(weight[win],1)-1.
  - On a burst re-grant, decrement by 1 (never below 0).
  - Not modified by resp.
- mode and weight are sampled only at the arbitration cycle; changing them mid-BUSY has no effect on the current grant.
- Request drop during BUSY: grant_o and comreq are held until resp. There is no abort. ack is still driven to grant_o.
- req all zero in IDLE: stay IDLE, grant_o holds its last value.
- N_REQ=1: grant_o is always 0; the block acts as a pure comreq/ack handshake with credit ignored.
- Reset mid-BUSY: immediate return to reset values; a later resp is ignored.
- Combinational path req->ack: none. Only grant_o, state and resp feed ack.

Decomposition:
- Package ivs_dma_pkg:
  - MODE_RR=1'b0, MODE_FIX=1'b1
  - state encoding ST_IDLE/ST_BUSY
  - function to extract weight field i
- Sub-module ivs_rr_pick: purely combinational rotate-and-priority-encode.
  - Inputs: req, last index, mode.
  - Outputs: winner index, any.
  - Parametrised by N_REQ; reusable by other IVS arbiters.
- Top holds the FSM, grant register, credit counter and ack decode.

Test Plan:
- Reset, then req=4'b1111, mode=0, weights=1, resp 3 cycles after each comreq -> grants 1,2,3,0,1; ack one-hot 0010,0100,1000,0001 coincident with resp; comreq low exactly 1 cycle between transactions.
- mode=1, req=4'b1010 continuous -> every grant goes to 1; req[1] dropped -> grant 3.
- mode=0, weight[2]=3, req=4'b0101, last grant 0 -> sequence 2,2,2,0,2,2,2,0.
- req=4'b0100 raised, then dropped one cycle into BUSY -> grant_o=2 and comreq held until resp, ack=4'b0100, then IDLE with comreq=0.
- resp pulsed in IDLE with req=0 -> ack=0, comreq stays 0. rst_n asserted mid-BUSY -> comreq=0, grant_o=0 immediately; a resp pulsed after reset release gives ack=0.
- N_REQ=3 build, req=3'b111, mode=0 -> grants 1,2,0,1; N_REQ=1 build, req=1 -> comreq/ack handshake with grant_o=0.
